// File: rtl/spi_slave_ctrl_pkg.sv
// spi_slave_ctrl_pkg: shared state encoding, default widths and command
// word layout for the SPI slave register-access front end.
package spi_slave_ctrl_pkg;

  // Default register address / data widths.
  localparam int SPI_ADDR_BITS_DEF = 7;
  localparam int SPI_DATA_BITS_DEF = 16;

  // Frame decoder states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_t;

  // The R/W flag (1 = read) sits directly above the address bits.
  function automatic int spi_rw_bit_pos(input int addr_bits);
    return addr_bits;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: brings one asynchronous pad input into the mclk domain
// (two flops), keeps a history flop and produces registered one-cycle
// rise/fall pulses of the synchronised level.
module spi_sync_edge (
  input  logic mclk,
  input  logic rst,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_hist;
  logic r_rise;
  logic r_fall;

  // Synchronise the pin, then compare against the previous level for edges
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_hist <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_hist <= r_sync;
      r_rise <= r_sync & ~r_hist;
      r_fall <= ~r_sync & r_hist;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI mode-0 slave that decodes {R/W, address, data}
// frames into single-cycle register-file write/read strobes.
// Optional build macro SPI_ADDR_AUTOINC_EN: burst transfers with
// address auto-increment instead of one word per frame.
module spi_slave_ctrl
  import spi_slave_ctrl_pkg::*;
#(
  parameter int ADDR_BITS = SPI_ADDR_BITS_DEF,
  parameter int DATA_BITS = SPI_DATA_BITS_DEF
) (
  input  logic                 mclk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 sc,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe_n,
  output logic [ADDR_BITS-1:0] reg_addr,
  output logic [DATA_BITS-1:0] reg_wdata,
  output logic                 reg_we,
  output logic                 reg_re,
  input  logic [DATA_BITS-1:0] reg_rdata
);

  localparam int CMD_BITS = 1 + ADDR_BITS;
  localparam int SHIFT_W  = (CMD_BITS > DATA_BITS) ? CMD_BITS : DATA_BITS;
  localparam int CNT_W    = $clog2(SHIFT_W + 1);
  localparam int RW_POS   = spi_rw_bit_pos(ADDR_BITS);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  logic w_sclk_sync_unused, w_sclk_rise, w_sclk_fall;
  logic w_sc_sync, w_sc_rise, w_sc_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;
  logic w_rise, w_fall;

  spi_state_t           r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [SHIFT_W-1:0]   r_shift, w_shift_next, w_shift_in;
  logic [ADDR_BITS-1:0] r_addr, w_addr_next;
  logic [DATA_BITS-1:0] r_wdata, w_wdata_next;
  logic [DATA_BITS-1:0] r_tx, w_tx_next;
  logic                 r_we, w_we_next;
  logic                 r_re, w_re_next;
  logic                 r_re_d;
  logic                 r_first_fall, w_first_fall_next;

  spi_sync_edge u_sclk_sync (
    .mclk(mclk), .rst(rst), .i_pin(sclk),
    .o_sync(w_sclk_sync_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge u_sc_sync (
    .mclk(mclk), .rst(rst), .i_pin(sc),
    .o_sync(w_sc_sync), .o_rise(w_sc_rise), .o_fall(w_sc_fall)
  );

  spi_sync_edge u_mosi_sync (
    .mclk(mclk), .rst(rst), .i_pin(mosi),
    .o_sync(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  // sclk edges only count while the slave is selected
  assign w_rise     = w_sclk_rise & ~w_sc_sync;
  assign w_fall     = w_sclk_fall & ~w_sc_sync;
  assign w_shift_in = {r_shift[SHIFT_W-2:0], w_mosi};

  // State register
  always_ff @(posedge mclk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state and datapath updates; deselect aborts without any strobe
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_shift_next      = r_shift;
    w_addr_next       = r_addr;
    w_wdata_next      = r_wdata;
    w_tx_next         = r_tx;
    w_we_next         = 1'b0;
    w_re_next         = 1'b0;
    w_first_fall_next = r_first_fall;
`ifdef SPI_ADDR_AUTOINC_EN
    if (r_we) w_addr_next = r_addr + ADDR_BITS'(1);
`endif
    if (w_sc_rise) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sc_fall) begin
            w_state_next = ST_CMD;
            w_cnt_next   = '0;
          end
        end
        ST_CMD: begin
          if (w_rise) begin
            w_shift_next = w_shift_in;
            w_cnt_next   = r_cnt + CNT_W'(1);
            if (r_cnt == CMD_LAST) begin
              w_cnt_next  = '0;
              w_addr_next = w_shift_in[ADDR_BITS-1:0];
              if (w_shift_in[RW_POS]) begin
                w_re_next         = 1'b1;
                w_first_fall_next = 1'b1;
                w_state_next      = ST_RDATA;
              end else begin
                w_state_next = ST_WDATA;
              end
            end
          end
        end
        ST_WDATA: begin
          if (w_rise) begin
            w_shift_next = w_shift_in;
            w_cnt_next   = r_cnt + CNT_W'(1);
            if (r_cnt == DATA_LAST) begin
              w_cnt_next   = '0;
              w_wdata_next = w_shift_in[DATA_BITS-1:0];
              w_we_next    = 1'b1;
`ifndef SPI_ADDR_AUTOINC_EN
              w_state_next = ST_DONE;
`endif
            end
          end
        end
        ST_RDATA: begin
          // The fall right after a word is requested precedes the reload
          if (w_fall) begin
            if (r_first_fall) w_first_fall_next = 1'b0;
            else              w_tx_next = {r_tx[DATA_BITS-2:0], 1'b0};
          end
          if (w_rise) begin
            w_cnt_next = r_cnt + CNT_W'(1);
            if (r_cnt == DATA_LAST) begin
              w_cnt_next = '0;
`ifdef SPI_ADDR_AUTOINC_EN
              w_addr_next       = r_addr + ADDR_BITS'(1);
              w_re_next         = 1'b1;
              w_first_fall_next = 1'b1;
`else
              w_state_next = ST_DONE;
`endif
            end
          end
        end
        ST_DONE: begin
          w_state_next = ST_DONE;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
    // Read data arrives one cycle after the strobe; load wins over a shift
    if (r_re_d) w_tx_next = reg_rdata;
  end

  // Datapath registers
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_tx         <= '0;
      r_we         <= 1'b0;
      r_re         <= 1'b0;
      r_re_d       <= 1'b0;
      r_first_fall <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_next;
      r_shift      <= w_shift_next;
      r_addr       <= w_addr_next;
      r_wdata      <= w_wdata_next;
      r_tx         <= w_tx_next;
      r_we         <= w_we_next;
      r_re         <= w_re_next;
      r_re_d       <= r_re;
      r_first_fall <= w_first_fall_next;
    end
  end

  assign miso      = r_tx[DATA_BITS-1];
  assign miso_oe_n = (r_state != ST_RDATA);
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- SPI slave front end directly downstream of the pad ring; consumes the pad-buffered sclk/sc/mosi and drives miso/miso_oe_n back to the pads.
- Oversamples the SPI pins in the mclk domain and decodes frames into single-cycle register-file write/read strobes for the FSM/config registers.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first; mclk ≥ 8× sclk frequency.

Parameters:
- ADDR_BITS, 7, register address width; command word is 1+ADDR_BITS bits.
- DATA_BITS, 16, register data width per data word.

Ports:
- mclk  input  1  system clock; single clock domain.
- rst  input  1  synchronous reset, active-high.
- sclk  input  1  SPI clock from pad, asynchronous to mclk.
- sc  input  1  SPI chip select from pad, active-low (0 = frame active).
- mosi  input  1  SPI data in from pad.
- miso  output  1  SPI data out to pad.
- miso_oe_n  output  1  miso output enable, active-low.
- reg_addr  output  ADDR_BITS  register address for current access.
- reg_wdata  output  DATA_BITS  write data, valid while reg_we=1.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read strobe.
- reg_rdata  input  DATA_BITS  read data, valid exactly 1 mclk after reg_re.

Behaviour:
- Reset values: miso=0, miso_oe_n=1, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, state=IDLE, all shift registers and counters 0.
- Synchronisation: sclk, sc, mosi each pass through a 2-flop synchroniser plus a history flop. rise/fall = one-cycle pulses on synchronised sclk, active only while synchronised sc=0. Pin-to-pulse latency is 3 mclk.
- Frame: command word first (bit MSB = R/W, 1 = read; lower ADDR_BITS = address), then DATA_BITS data bits.
- State machine:
  - IDLE: enter CMD on synchronised sc falling.
  - CMD: shift mosi on each rise; bit counter counts up to 1+ADDR_BITS.
    - On the last command bit, latch reg_addr.
    - Write: go to WDATA.
    - Read: assert reg_re for 1 cycle, go to RDATA.
  - WDATA: shift mosi on each rise. After DATA_BITS bits, on the next mclk, drive reg_wdata and pulse reg_we for 1 cycle, then go to DONE.
  - RDATA:
    - One mclk after reg_re, load reg_rdata into tx shift register; miso_oe_n=0 for the whole of RDATA.
    - miso always equals tx MSB.
    - The first fall in RDATA does not shift; each later fall shifts left by 1.
    - After DATA_BITS rises, go to DONE.
  - DONE: ignore edges, miso_oe_n=1; return to IDLE on sc rising.
- Boundaries:
  - sc rising in any state returns to IDLE within 1 cycle, with miso_oe_n=1 and no strobe issued; a partial write is never committed.
  - sclk edges while sc=1 are ignored.
  - rst asserted mid-frame forces reset values on the next mclk edge. The bench releases rst only while sc=1; a frame already in progress at release is ignored until sc toggles.
  - reg_we and reg_re are never asserted in the same cycle.

Optional Feature:
- Macro: SPI_ADDR_AUTOINC_EN.
- Defined:
  - WDATA/RDATA do not go to DONE after a word; they wrap the bit counter and continue (burst).
  - reg_addr increments by 1 (mod 2^ADDR_BITS, so all-ones wraps to 0) after each reg_we, or before each subsequent reg_re.
  - Reads issue a new reg_re after each word's final rise; tx reload occurs before the next fall.
- Undefined: exactly one word per frame; extra clocks are ignored in DONE.

Decomposition:
- Shared `define header holds the state encodings (IDLE, CMD, WDATA, RDATA, DONE), the default ADDR_BITS/DATA_BITS, and the R/W bit position.
- One natural sub-module, spi_sync_edge: 2-flop synchroniser plus edge detect with sync, rise and fall outputs; instantiated for sclk and sc. mosi uses its sync output only.

Test Plan:
- Write: sc low, clock cmd 0x05 then data 0xA5C3, sc high → exactly one reg_we pulse with reg_addr=0x05, reg_wdata=0xA5C3; miso_oe_n stays 1.
- Read: cmd 0x85, model returns reg_rdata=0x1234 one cycle after reg_re → one reg_re with addr 0x05; miso samples on 16 rises = 0001001000110100; miso_oe_n=0 only during those bits.
- Abort: write cmd 0x05, then sc high after 4 data bits → no reg_we; the next full write 0x06/0xFFFF commits correctly.
- Reset mid-frame: assert rst during bit 10 of a write → all outputs at reset values the next cycle, no reg_we; a new frame after sc toggles works.
- Edge noise: toggle sclk 20 times with sc=1 → no strobes, state stays IDLE, miso_oe_n=1.
- Burst (SPI_ADDR_AUTOINC_EN): write cmd 0x7E with 3 words 0x0001/0x0002/0x0003 → reg_we at addresses 0x7E, 0x7F, 0x00. Same stimulus without the macro → single reg_we at 0x7E with data 0x0001.
